// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline registers and the hazard/stall/flush scheduler.
// The pipeline side uses modport master; pipe_ctrl uses modport slave.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              load_use_i;
  logic              mdu_start_i;
  logic              mdu_done_i;
  logic              ext_hold_i;
  logic              stall_pc_o;
  logic              stall_if_id_o;
  logic              stall_id_ex_o;
  logic              flush_if_id_o;
  logic              flush_id_ex_o;
  logic              jump_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              mdu_abort_o;
  logic [31:0]       stall_cnt_o;
  logic [31:0]       flush_cnt_o;

  modport master (
    output jump_en_i, jump_addr_i, load_use_i, mdu_start_i, mdu_done_i, ext_hold_i,
    input  stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o,
    input  jump_o, jump_addr_o, mdu_abort_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, load_use_i, mdu_start_i, mdu_done_i, ext_hold_i,
    output stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o,
    output jump_o, jump_addr_o, mdu_abort_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/stall/flush scheduler for the 5-stage core (jump, load-use, MDU wait, bus hold).
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int MDU_TIMEOUT = 64,
  parameter int TO_W        = 8
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN, MDU_WAIT, JMP_PEND} state_t;

  localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(MDU_TIMEOUT - 1);

  state_t            r_state, w_state_next;
  logic [TO_W-1:0]   r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_jaddr, w_jaddr_next;
  logic              w_stall_pc, w_stall_if_id, w_stall_id_ex;
  logic              w_flush_if_id, w_flush_id_ex, w_jump, w_abort;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_jaddr_next  = r_jaddr;
    w_stall_pc    = 1'b0;
    w_stall_if_id = 1'b0;
    w_stall_id_ex = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_jump        = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.jump_en_i && !bus.ext_hold_i) begin
          w_jump        = 1'b1;
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end else if (bus.jump_en_i) begin
          w_jaddr_next  = bus.jump_addr_i;
          {w_stall_pc, w_stall_if_id, w_stall_id_ex} = 3'b111;
          w_state_next  = JMP_PEND;
        end else if (bus.mdu_start_i) begin
          {w_stall_pc, w_stall_if_id, w_stall_id_ex} = 3'b111;
          w_cnt_next    = '0;
          w_state_next  = MDU_WAIT;
        end else if (bus.ext_hold_i) begin
          {w_stall_pc, w_stall_if_id, w_stall_id_ex} = 3'b111;
        end else if (bus.load_use_i) begin
          w_stall_pc    = 1'b1;
          w_stall_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end
      end
      MDU_WAIT: begin
        {w_stall_pc, w_stall_if_id, w_stall_id_ex} = 3'b111;
        // A done pulse on the timeout cycle still counts as a normal completion.
        if (bus.mdu_done_i) begin
          w_state_next  = RUN;
        end else if (r_cnt == LP_TO_LAST) begin
          w_abort       = 1'b1;
          w_flush_id_ex = 1'b1;
          w_state_next  = RUN;
        end else begin
          w_cnt_next    = r_cnt + 1'b1;
        end
      end
      JMP_PEND: begin
        if (bus.ext_hold_i) begin
          {w_stall_pc, w_stall_if_id, w_stall_id_ex} = 3'b111;
        end else begin
          w_jump        = 1'b1;
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
          w_state_next  = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_jaddr <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_jaddr <= w_jaddr_next;
    end
  end

  // Outputs are forced low during reset; a flush always overrides a stall on the same register.
  assign bus.stall_pc_o    = rst & w_stall_pc;
  assign bus.stall_if_id_o = rst & w_stall_if_id & ~w_flush_if_id;
  assign bus.stall_id_ex_o = rst & w_stall_id_ex & ~w_flush_id_ex;
  assign bus.flush_if_id_o = rst & w_flush_if_id;
  assign bus.flush_id_ex_o = rst & w_flush_id_ex;
  assign bus.jump_o        = rst & w_jump;
  assign bus.mdu_abort_o   = rst & w_abort;
  assign bus.jump_addr_o   = !rst ? '0 : ((r_state == JMP_PEND) ? r_jaddr : bus.jump_addr_i);

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {31'd0, bus.stall_pc_o};
      r_flush_cnt <= r_flush_cnt + {31'd0, bus.flush_id_ex_o};
    end
  end

  assign bus.stall_cnt_o = rst ? r_stall_cnt : 32'd0;
  assign bus.flush_cnt_o = rst ? r_flush_cnt : 32'd0;
`else
  assign bus.stall_cnt_o = 32'd0;
  assign bus.flush_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each stimulus cycle queues its expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(32)) bus ();

  pipe_ctrl #(.ADDR_W(32), .MDU_TIMEOUT(8), .TO_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // flag order: {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, jump, abort}
  localparam logic [6:0] F_Z  = 7'b0000000;
  localparam logic [6:0] F_S3 = 7'b1110000;
  localparam logic [6:0] F_J  = 7'b0001110;
  localparam logic [6:0] F_LU = 7'b1100100;
  localparam logic [6:0] F_AB = 7'b1100101;

  typedef struct {
    string       name;
    logic [6:0]  flags;
    logic [31:0] addr;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_sc = 0;
  logic [31:0] exp_fc = 0;

  task automatic step(input logic r, input logic je, input logic [31:0] ja, input logic lu,
                      input logic ms, input logic md, input logic hd,
                      input logic [6:0] ef, input logic [31:0] ea, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.jump_en_i   = je;
    bus.jump_addr_i = ja;
    bus.load_use_i  = lu;
    bus.mdu_start_i = ms;
    bus.mdu_done_i  = md;
    bus.ext_hold_i  = hd;
    e.name  = nm;
    e.flags = ef;
    e.addr  = ea;
`ifdef PIPE_PERF_CNT_EN
    e.scnt = r ? exp_sc : 32'd0;
    e.fcnt = r ? exp_fc : 32'd0;
    if (!r) begin
      exp_sc = 0;
      exp_fc = 0;
    end else begin
      exp_sc = exp_sc + {31'd0, ef[6]};
      exp_fc = exp_fc + {31'd0, ef[2]};
    end
`else
    e.scnt = 32'd0;
    e.fcnt = 32'd0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic run(input logic je, input logic [31:0] ja, input logic lu, input logic ms,
                     input logic md, input logic hd, input logic [6:0] ef,
                     input logic [31:0] ea, input string nm);
    step(1'b1, je, ja, lu, ms, md, hd, ef, ea, nm);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e   = sb_q.pop_front();
      got = {bus.stall_pc_o, bus.stall_if_id_o, bus.stall_id_ex_o, bus.flush_if_id_o,
             bus.flush_id_ex_o, bus.jump_o, bus.mdu_abort_o};
      checks = checks + 3;
      if (got !== e.flags) begin
        errors = errors + 1;
        $display("FAIL %s flags got %b want %b", e.name, got, e.flags);
      end
      if (bus.jump_addr_o !== e.addr) begin
        errors = errors + 1;
        $display("FAIL %s jump_addr got %h want %h", e.name, bus.jump_addr_o, e.addr);
      end
      if (bus.stall_cnt_o !== e.scnt || bus.flush_cnt_o !== e.fcnt) begin
        errors = errors + 1;
        $display("FAIL %s perf got %0d/%0d want %0d/%0d", e.name, bus.stall_cnt_o,
                 bus.flush_cnt_o, e.scnt, e.fcnt);
      end
      $display("chk %-12s flags=%b addr=%h scnt=%0d fcnt=%0d", e.name, got, bus.jump_addr_o,
               bus.stall_cnt_o, bus.flush_cnt_o);
    end
  end

  initial begin
    bus.jump_en_i   = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.load_use_i  = 1'b0;
    bus.mdu_start_i = 1'b0;
    bus.mdu_done_i  = 1'b0;
    bus.ext_hold_i  = 1'b0;

    // reset: every output low even with requests asserted
    step(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, F_Z, 32'h0, "rst_a");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h0, "rst_b");
    run(1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h44, "idle");

    // T1 jump without hold
    run(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, F_J, 32'h80, "t1_jump");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h0, "t1_after");

    // T2 load-use bubble
    run(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, F_LU, 32'h0, "t2_lu");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h0, "t2_after");
    run(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, F_S3, 32'h0, "hold_lu");

    // T3 MDU done five cycles after start; a jump during the wait is ignored
    run(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, F_S3, 32'h0, "t3_start");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_S3, 32'h0, "t3_w1");
    run(1'b1, 32'h90, 1'b1, 1'b0, 1'b0, 1'b0, F_S3, 32'h90, "t3_w2_jmp");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_S3, 32'h0, "t3_w3");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_S3, 32'h0, "t3_w4");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, F_S3, 32'h0, "t3_done");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h0, "t3_release");

    // T4 timeout after 8 wait cycles
    run(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, F_S3, 32'h0, "t4_start");
    for (int i = 0; i < 7; i++)
      run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_S3, 32'h0, "t4_wait");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_AB, 32'h0, "t4_abort");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h0, "t4_run");

    // done on the timeout cycle: no abort
    run(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, F_S3, 32'h0, "dt_start");
    for (int i = 0; i < 7; i++)
      run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_S3, 32'h0, "dt_wait");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, F_S3, 32'h0, "dt_done");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h0, "dt_run");

    // T5 jump under bus hold, redirected exactly once when hold drops
    run(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, F_S3, 32'h100, "t5_latch");
    run(1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, F_S3, 32'h100, "t5_hold2");
    run(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b1, F_S3, 32'h100, "t5_hold3");
    run(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, F_J, 32'h100, "t5_jump");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h0, "t5_once");

    // T6 reset during MDU wait and during a pending jump
    run(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, F_S3, 32'h0, "t6_start");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_S3, 32'h0, "t6_wait");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h0, "t6_rst");
    run(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h0, "t6_run");
    run(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, F_LU, 32'h0, "t6_lu");
    run(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, F_S3, 32'h300, "jp_latch");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, F_Z, 32'h0, "jp_rst");
    run(1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, F_Z, 32'h44, "jp_discard");

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain queue got %0d want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
